// File: rtl/speicher_arbiter_pkg.sv
// Shared constants for the RAM arbiter: FSM encoding, requester IDs, I/O window helper.
package speicher_arbiter_pkg;

  // Access sequencer states
  localparam logic [1:0] LEERLAUF  = 2'd0;
  localparam logic [1:0] ANSTOSS   = 2'd1;
  localparam logic [1:0] WARTEN    = 2'd2;
  // Only reachable when the LED I/O window is built in
  localparam logic [1:0] IO_FERTIG = 2'd3;

  // Requester IDs, also the bit positions in the request/grant vectors
  localparam logic HOLEN = 1'b0;
  localparam logic DATEN = 1'b1;

  localparam int unsigned LED_BREITE = 8;

  // Data-side address bit that selects the I/O window
  function automatic int unsigned io_bit(input int unsigned adrbreite);
    return adrbreite - 1;
  endfunction

endpackage

// File: rtl/speicher_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter. Grant is combinational from the requests; the last
// winner is remembered so that a tie goes to the other requester.
module speicher_arbiter_rr_arbiter2
  import speicher_arbiter_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_req,
  input  logic       i_enable,
  output logic [1:0] o_grant
);

  logic       r_letzter;
  logic [1:0] w_grant;

  // One-hot grant; a tie goes to whoever did not win last time
  always_comb begin
    w_grant = 2'b00;
    if (i_enable) begin
      if (i_req == 2'b11) begin
        w_grant[DATEN] = (r_letzter == HOLEN);
        w_grant[HOLEN] = (r_letzter == DATEN);
      end else begin
        w_grant = i_req;
      end
    end
  end

  // Remember the most recent winner; after reset data wins the first tie
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_letzter <= HOLEN;
    end else if (w_grant[DATEN]) begin
      r_letzter <= DATEN;
    end else if (w_grant[HOLEN]) begin
      r_letzter <= HOLEN;
    end
  end

  assign o_grant = w_grant;

endmodule

// File: rtl/speicher_arbiter.sv
// Shares one single-port RAM between instruction fetch and the load/store unit.
// Each access: grant + strobe, one strobe cycle, then wait for the RAM flag.
// Optional feature macro: SPEICHER_IO_LED_EN (data addresses with the MSB set
// address an 8-bit LED register instead of the RAM).
module speicher_arbiter
  import speicher_arbiter_pkg::*;
#(
  parameter int unsigned WORDSIZE  = 32,
  parameter int unsigned WORDS     = 32,
  parameter int unsigned ADRBREITE = 32
) (
  input  logic                     i_Clock,
  input  logic                     i_Reset,
  input  logic                     i_HolenAn,
  input  logic [ADRBREITE-1:0]     i_HolenAdresse,
  output logic [WORDSIZE-1:0]      o_HolenDaten,
  output logic                     o_HolenBereit,
  input  logic                     i_LadenAn,
  input  logic                     i_SpeichernAn,
  input  logic [ADRBREITE-1:0]     i_DatenAdresse,
  input  logic [WORDSIZE-1:0]      i_DatenSchreiben,
  output logic [WORDSIZE-1:0]      o_DatenLesen,
  output logic                     o_DatenFertig,
  output logic                     o_RamLesenAn,
  output logic                     o_RamSchreibenAn,
  output logic [$clog2(WORDS)-1:0] o_RamAdresse,
  output logic [WORDSIZE-1:0]      o_RamDatenRein,
  input  logic [WORDSIZE-1:0]      i_RamDatenRaus,
  input  logic                     i_RamDatenBereit,
  input  logic                     i_RamDatenGeschrieben
`ifdef SPEICHER_IO_LED_EN
  ,
  output logic [LED_BREITE-1:0]    o_Leds
`endif
);

  localparam int unsigned RAB = $clog2(WORDS);

  logic [1:0]          r_zustand;
  logic                r_ist_daten;
  logic                r_ist_schreiben;
  logic [WORDSIZE-1:0] r_holen_daten;
  logic                r_holen_bereit;
  logic [WORDSIZE-1:0] r_daten_lesen;
  logic                r_daten_fertig;
  logic                r_ram_lesen;
  logic                r_ram_schreiben;
  logic [RAB-1:0]      r_ram_adresse;
  logic [WORDSIZE-1:0] r_ram_daten_rein;

  logic [1:0] w_req;
  logic [1:0] w_grant;
  logic       w_ram_flag;
  logic       w_unused;

  // Address bits above the RAM depth are dropped (wrap-around)
  assign w_unused = ^{i_HolenAdresse[ADRBREITE-1:RAB], i_DatenAdresse[ADRBREITE-1:RAB]};

  assign w_req[HOLEN] = i_HolenAn;
  assign w_req[DATEN] = i_LadenAn | i_SpeichernAn;

  // The completion flag that matters depends on the kind of access in flight
  assign w_ram_flag = r_ist_schreiben ? i_RamDatenGeschrieben : i_RamDatenBereit;

  speicher_arbiter_rr_arbiter2 u_rr (
    .i_clk    (i_Clock),
    .i_reset  (i_Reset),
    .i_req    (w_req),
    .i_enable (r_zustand == LEERLAUF),
    .o_grant  (w_grant)
  );

`ifdef SPEICHER_IO_LED_EN
  localparam int unsigned IO_BIT = io_bit(ADRBREITE);
  logic [LED_BREITE-1:0] r_leds;
  logic                  w_io;

  assign w_io   = i_DatenAdresse[IO_BIT];
  assign o_Leds = r_leds;

  // LED register: written at grant time of an I/O store
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_leds <= '0;
    end else if (w_grant[DATEN] && w_io && i_SpeichernAn) begin
      r_leds <= i_DatenSchreiben[LED_BREITE-1:0];
    end
  end
`else
  logic w_io;
  assign w_io = 1'b0;
`endif

  // Access sequencer: grant/latch in LEERLAUF, one strobe cycle, wait for RAM flag
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_zustand        <= LEERLAUF;
      r_ist_daten      <= 1'b0;
      r_ist_schreiben  <= 1'b0;
      r_holen_daten    <= '0;
      r_holen_bereit   <= 1'b0;
      r_daten_lesen    <= '0;
      r_daten_fertig   <= 1'b0;
      r_ram_lesen      <= 1'b0;
      r_ram_schreiben  <= 1'b0;
      r_ram_adresse    <= '0;
      r_ram_daten_rein <= '0;
    end else begin
      r_holen_bereit <= 1'b0;
      r_daten_fertig <= 1'b0;
      case (r_zustand)
        LEERLAUF: begin
          if (w_grant[DATEN]) begin
            r_ist_daten     <= 1'b1;
            // Load and store together count as a store
            r_ist_schreiben <= i_SpeichernAn;
            if (w_io) begin
              r_zustand <= IO_FERTIG;
            end else begin
              r_ram_adresse    <= i_DatenAdresse[RAB-1:0];
              r_ram_daten_rein <= i_DatenSchreiben;
              r_ram_lesen      <= ~i_SpeichernAn;
              r_ram_schreiben  <= i_SpeichernAn;
              r_zustand        <= ANSTOSS;
            end
          end else if (w_grant[HOLEN]) begin
            r_ist_daten     <= 1'b0;
            r_ist_schreiben <= 1'b0;
            r_ram_adresse   <= i_HolenAdresse[RAB-1:0];
            r_ram_lesen     <= 1'b1;
            r_zustand       <= ANSTOSS;
          end
        end
        ANSTOSS: begin
          r_ram_lesen     <= 1'b0;
          r_ram_schreiben <= 1'b0;
          r_zustand       <= WARTEN;
        end
        WARTEN: begin
          if (w_ram_flag) begin
            if (r_ist_daten) begin
              r_daten_fertig <= 1'b1;
              if (!r_ist_schreiben) r_daten_lesen <= i_RamDatenRaus;
            end else begin
              r_holen_bereit <= 1'b1;
              r_holen_daten  <= i_RamDatenRaus;
            end
            r_zustand <= LEERLAUF;
          end
        end
`ifdef SPEICHER_IO_LED_EN
        IO_FERTIG: begin
          r_daten_fertig <= 1'b1;
          if (!r_ist_schreiben) begin
            r_daten_lesen <= {{(WORDSIZE - LED_BREITE){1'b0}}, r_leds};
          end
          r_zustand <= LEERLAUF;
        end
`endif
        default: r_zustand <= LEERLAUF;
      endcase
    end
  end

  assign o_HolenDaten     = r_holen_daten;
  assign o_HolenBereit    = r_holen_bereit;
  assign o_DatenLesen     = r_daten_lesen;
  assign o_DatenFertig    = r_daten_fertig;
  assign o_RamLesenAn     = r_ram_lesen;
  assign o_RamSchreibenAn = r_ram_schreiben;
  assign o_RamAdresse     = r_ram_adresse;
  assign o_RamDatenRein   = r_ram_daten_rein;

endmodule

// File: tb/tb_speicher_arbiter.sv
// Bench for speicher_arbiter: RAM model with programmable response delay, a
// transaction-level model (round-robin order, shadow memory, latency) checked every
// cycle, plus literal expectations from hand calculation.
module tb_speicher_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        HolenAn, LadenAn, SpeichernAn;
  logic [31:0] HolenAdresse, DatenAdresse, DatenSchreiben;
  logic [31:0] HolenDaten, DatenLesen;
  logic        HolenBereit, DatenFertig;
  logic        RamLesenAn, RamSchreibenAn;
  logic [4:0]  RamAdresse;
  logic [31:0] RamDatenRein, RamDatenRaus;
  logic        RamDatenBereit, RamDatenGeschrieben;
`ifdef SPEICHER_IO_LED_EN
  logic [7:0]  Leds;
`endif

  always #5 clk = ~clk;

  speicher_arbiter #(.WORDSIZE(32), .WORDS(32), .ADRBREITE(32)) dut (
    .i_Clock              (clk),
    .i_Reset              (rst),
    .i_HolenAn            (HolenAn),
    .i_HolenAdresse       (HolenAdresse),
    .o_HolenDaten         (HolenDaten),
    .o_HolenBereit        (HolenBereit),
    .i_LadenAn            (LadenAn),
    .i_SpeichernAn        (SpeichernAn),
    .i_DatenAdresse       (DatenAdresse),
    .i_DatenSchreiben     (DatenSchreiben),
    .o_DatenLesen         (DatenLesen),
    .o_DatenFertig        (DatenFertig),
    .o_RamLesenAn         (RamLesenAn),
    .o_RamSchreibenAn     (RamSchreibenAn),
    .o_RamAdresse         (RamAdresse),
    .o_RamDatenRein       (RamDatenRein),
    .i_RamDatenRaus       (RamDatenRaus),
    .i_RamDatenBereit     (RamDatenBereit),
    .i_RamDatenGeschrieben(RamDatenGeschrieben)
`ifdef SPEICHER_IO_LED_EN
    ,
    .o_Leds               (Leds)
`endif
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- RAM model (environment) ----------------
  logic [31:0] ram_mem [32];
  int          ram_delay = 0;
  logic        ram_pend = 1'b0;
  logic        ram_pend_wr = 1'b0;
  logic [31:0] ram_pend_rd = '0;
  int          ram_cnt = 0;

  always @(posedge clk) begin
    RamDatenBereit      <= 1'b0;
    RamDatenGeschrieben <= 1'b0;
    if (rst) begin
      ram_pend <= 1'b0;
    end else if (RamLesenAn || RamSchreibenAn) begin
      if (RamSchreibenAn) ram_mem[RamAdresse] <= RamDatenRein;
      if (ram_delay == 0) begin
        if (RamSchreibenAn) RamDatenGeschrieben <= 1'b1;
        else begin
          RamDatenBereit <= 1'b1;
          RamDatenRaus   <= ram_mem[RamAdresse];
        end
      end else begin
        ram_pend    <= 1'b1;
        ram_pend_wr <= RamSchreibenAn;
        ram_pend_rd <= ram_mem[RamAdresse];
        ram_cnt     <= ram_delay;
      end
    end else if (ram_pend) begin
      if (ram_cnt == 1) begin
        ram_pend <= 1'b0;
        if (ram_pend_wr) RamDatenGeschrieben <= 1'b1;
        else begin
          RamDatenBereit <= 1'b1;
          RamDatenRaus   <= ram_pend_rd;
        end
      end else begin
        ram_cnt <= ram_cnt - 1;
      end
    end
  end

  // ---------------- Transaction model ----------------
  typedef struct {
    bit          data;
    bit          wr;
    logic [4:0]  adr;
    logic [31:0] wd;
    int          delay;
  } acc_t;

  acc_t        exp_q[$];
  acc_t        cur;
  bit          cur_act = 1'b0;
  int          age = 0;
  bit          chk_en = 1'b0;
  logic [31:0] model_mem [32];
  bit          m_last_data = 1'b0;
  logic [4:0]  seen_adr[$];
  int          wr_strobes = 0;

  function automatic logic [31:0] init_word(input int i);
    return (i == 2) ? 32'h9BFF_001F : 32'h1000_0000 + 32'(i);
  endfunction

  // Round-robin rule: lone requester wins; tie goes to the one that lost last
  function automatic bit model_pick(input bit h, input bit d);
    bit p;
    p = (h && d) ? ~m_last_data : d;
    m_last_data = p;
    return p;
  endfunction

  // Enqueue the accesses that a level-held request pattern produces, in grant order
  task automatic expect_acc(input bit wr, input logic [31:0] hadr, input logic [31:0] dadr,
                            input logic [31:0] wd, input int nh, input int nd);
    int   rh;
    int   rd;
    acc_t e;
    rh = nh;
    rd = nd;
    while (rh > 0 || rd > 0) begin
      e.data  = model_pick(rh > 0, rd > 0);
      e.wr    = e.data && wr;
      e.adr   = 5'((e.data ? dadr : hadr) % 32);
      e.wd    = wd;
      e.delay = ram_delay;
      exp_q.push_back(e);
      if (e.data) rd--;
      else rh--;
    end
  endtask

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (RamLesenAn || RamSchreibenAn) begin
      seen_adr.push_back(RamAdresse);
      if (RamSchreibenAn) wr_strobes++;
    end
    if (chk_en) begin
      chk("single_strobe", {31'b0, RamLesenAn & RamSchreibenAn}, 32'd0);
      if (RamLesenAn || RamSchreibenAn) begin
        if (cur_act || exp_q.size() == 0) flag_fail("unexpected_strobe");
        else begin
          cur     = exp_q.pop_front();
          cur_act = 1'b1;
          age     = 0;
          chk("strobe_is_write", {31'b0, RamSchreibenAn}, {31'b0, cur.wr});
          chk("ram_address", {27'b0, RamAdresse}, {27'b0, cur.adr});
          if (cur.wr) chk("ram_wdata", RamDatenRein, cur.wd);
        end
      end else if (cur_act) begin
        age++;
      end
      if (HolenBereit || DatenFertig) begin
        if (!cur_act) flag_fail("unexpected_pulse");
        else begin
          chk("latency", 32'(age), 32'(2 + cur.delay));
          chk("pulse_kind", {30'b0, HolenBereit, DatenFertig}, cur.data ? 32'd1 : 32'd2);
          if (!cur.data) chk("fetch_data", HolenDaten, model_mem[cur.adr]);
          else if (!cur.wr) chk("load_data", DatenLesen, model_mem[cur.adr]);
          else model_mem[cur.adr] = cur.wd;
          cur_act = 1'b0;
        end
      end else if (cur_act && age > 2 + cur.delay) begin
        flag_fail("missing_pulse");
        cur_act = 1'b0;
      end
    end
  end

  // ---------------- Core-side driver ----------------
  // Hold the requests; each pulse consumes one access; drop a request in its last pulse cycle
  task automatic run_req(input bit h, input bit ld, input bit st, input logic [31:0] hadr,
                         input logic [31:0] dadr, input logic [31:0] wd,
                         input int nh, input int nd, output int cyc);
    int rh;
    int rd;
    rh = nh;
    rd = nd;
    cyc = 0;
    HolenAn = h; HolenAdresse = hadr;
    LadenAn = ld; SpeichernAn = st; DatenAdresse = dadr; DatenSchreiben = wd;
    while ((HolenAn || LadenAn || SpeichernAn) && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (HolenBereit) begin
        rh--;
        if (rh <= 0) HolenAn = 1'b0;
      end
      if (DatenFertig) begin
        rd--;
        if (rd <= 0) begin
          LadenAn = 1'b0;
          SpeichernAn = 1'b0;
        end
      end
    end
    chk("request_completed", {31'b0, HolenAn | LadenAn | SpeichernAn}, 32'd0);
    HolenAn = 1'b0; LadenAn = 1'b0; SpeichernAn = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int cyc;
  int pulses;
  int wr_before;

  initial begin
    for (int i = 0; i < 32; i++) begin
      ram_mem[i]   = init_word(i);
      model_mem[i] = init_word(i);
    end
    rst = 1'b1;
    HolenAn = 1'b0; LadenAn = 1'b0; SpeichernAn = 1'b0;
    HolenAdresse = '0; DatenAdresse = '0; DatenSchreiben = '0;
    cycles(2);
    chk("reset_holen_bereit", {31'b0, HolenBereit}, 32'd0);
    chk("reset_daten_fertig", {31'b0, DatenFertig}, 32'd0);
    chk("reset_strobes", {30'b0, RamLesenAn, RamSchreibenAn}, 32'd0);
    chk("reset_ram_adresse", {27'b0, RamAdresse}, 32'd0);
    chk("reset_holen_daten", HolenDaten, 32'd0);
`ifdef SPEICHER_IO_LED_EN
    chk("reset_leds", {24'b0, Leds}, 32'd0);
`endif
    rst = 1'b0;
    m_last_data = 1'b0;
    chk_en = 1'b1;

    // Fetch word 2
    expect_acc(1'b0, 32'd2, 32'd0, 32'd0, 1, 0);
    run_req(1'b1, 1'b0, 1'b0, 32'd2, 32'd0, 32'd0, 1, 0, cyc);
    chk("fetch_cycles", 32'(cyc), 32'd3);
    chk("fetch_literal", HolenDaten, 32'h9BFF_001F);

    // Store then load word 5
    expect_acc(1'b1, 32'd0, 32'd5, 32'hDEAD_BEEF, 0, 1);
    run_req(1'b0, 1'b0, 1'b1, 32'd0, 32'd5, 32'hDEAD_BEEF, 0, 1, cyc);
    chk("store_cycles", 32'(cyc), 32'd3);
    expect_acc(1'b0, 32'd0, 32'd5, 32'd0, 0, 1);
    run_req(1'b0, 1'b1, 1'b0, 32'd0, 32'd5, 32'd0, 0, 1, cyc);
    chk("load_literal", DatenLesen, 32'hDEAD_BEEF);

    // Load and store together behave as a store
    expect_acc(1'b1, 32'd0, 32'd11, 32'h0BAD_F00D, 0, 1);
    run_req(1'b0, 1'b1, 1'b1, 32'd0, 32'd11, 32'h0BAD_F00D, 0, 1, cyc);
    expect_acc(1'b0, 32'd0, 32'd11, 32'd0, 0, 1);
    run_req(1'b0, 1'b1, 1'b0, 32'd0, 32'd11, 32'd0, 0, 1, cyc);
    chk("both_is_store", DatenLesen, 32'h0BAD_F00D);

    // Address 37 wraps to word 5
    seen_adr.delete();
    expect_acc(1'b0, 32'd0, 32'd37, 32'd0, 0, 1);
    run_req(1'b0, 1'b1, 1'b0, 32'd0, 32'd37, 32'd0, 0, 1, cyc);
    chk("wrap_ram_adresse", (seen_adr.size() == 1) ? {27'b0, seen_adr[0]} : 32'hFFFF_FFFF, 32'd5);
    chk("wrap_data", DatenLesen, 32'hDEAD_BEEF);

    // Slow RAM: two extra cycles before the flag
    ram_delay = 2;
    expect_acc(1'b0, 32'd0, 32'd2, 32'd0, 0, 1);
    run_req(1'b0, 1'b1, 1'b0, 32'd0, 32'd2, 32'd0, 0, 1, cyc);
    chk("slow_cycles", 32'(cyc), 32'd5);
    ram_delay = 0;

`ifndef SPEICHER_IO_LED_EN
    // Without the I/O window the MSB is simply truncated
    expect_acc(1'b0, 32'd0, 32'h8000_0000, 32'd0, 0, 1);
    run_req(1'b0, 1'b1, 1'b0, 32'd0, 32'h8000_0000, 32'd0, 0, 1, cyc);
    chk("msb_truncated", DatenLesen, 32'h1000_0000);
`endif

    // Reset while waiting for a RAM that never answers
    cycles(1);
    chk_en = 1'b0;
    ram_delay = 1000;
    pulses = 0;
    HolenAn = 1'b1; HolenAdresse = 32'd3;
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      if (HolenBereit) pulses++;
    end
    chk("stall_no_pulse", 32'(pulses), 32'd0);
    rst = 1'b1;
    HolenAn = 1'b0;
    cycles(1);
    chk("midreset_pulses", {30'b0, HolenBereit, DatenFertig}, 32'd0);
    chk("midreset_strobes", {30'b0, RamLesenAn, RamSchreibenAn}, 32'd0);
    chk("midreset_holen_daten", HolenDaten, 32'd0);
    chk("midreset_daten_lesen", DatenLesen, 32'd0);
    chk("midreset_ram_rein", RamDatenRein, 32'd0);
    chk("midreset_ram_adresse", {27'b0, RamAdresse}, 32'd0);
    rst = 1'b0;
    ram_delay = 0;
    exp_q.delete();
    cur_act = 1'b0;
    m_last_data = 1'b0;
    cycles(2);
    chk("post_reset_idle", {29'b0, RamLesenAn, RamSchreibenAn, HolenBereit}, 32'd0);
    chk_en = 1'b1;

    // Tie from reset: data first, then alternating
    seen_adr.delete();
    expect_acc(1'b0, 32'd7, 32'd9, 32'd0, 2, 2);
    run_req(1'b1, 1'b1, 1'b0, 32'd7, 32'd9, 32'd0, 2, 2, cyc);
    chk("tie_cycles", 32'(cyc), 32'd12);
    chk("tie_count", 32'(seen_adr.size()), 32'd4);
    if (seen_adr.size() == 4) begin
      chk("tie_order0", {27'b0, seen_adr[0]}, 32'd9);
      chk("tie_order1", {27'b0, seen_adr[1]}, 32'd7);
      chk("tie_order2", {27'b0, seen_adr[2]}, 32'd9);
      chk("tie_order3", {27'b0, seen_adr[3]}, 32'd7);
    end

    // Clean fetch after everything
    expect_acc(1'b0, 32'd2, 32'd0, 32'd0, 1, 0);
    run_req(1'b1, 1'b0, 1'b0, 32'd2, 32'd0, 32'd0, 1, 0, cyc);
    chk("refetch_literal", HolenDaten, 32'h9BFF_001F);

`ifdef SPEICHER_IO_LED_EN
    // LED window: bypasses the RAM, completes one cycle after grant
    cycles(1);
    chk_en = 1'b0;
    wr_before = wr_strobes;
    m_last_data = model_pick(1'b0, 1'b1);
    run_req(1'b0, 1'b0, 1'b1, 32'd0, 32'h8000_0000, 32'h1234_00A5, 0, 1, cyc);
    chk("io_store_cycles", 32'(cyc), 32'd2);
    chk("io_leds", {24'b0, Leds}, 32'h0000_00A5);
    m_last_data = model_pick(1'b0, 1'b1);
    run_req(1'b0, 1'b1, 1'b0, 32'd0, 32'h8000_0000, 32'd0, 0, 1, cyc);
    chk("io_load_cycles", 32'(cyc), 32'd2);
    chk("io_load_data", DatenLesen, 32'h0000_00A5);
    chk("io_no_ram_write", 32'(wr_strobes - wr_before), 32'd0);
    cycles(1);
    chk_en = 1'b1;
    expect_acc(1'b0, 32'd0, 32'd0, 32'd0, 0, 1);
    run_req(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 0, 1, cyc);
    chk("io_ram0_kept", DatenLesen, 32'h1000_0000);
`endif

    cycles(3);
    chk("model_drained", 32'(exp_q.size()) + {31'b0, cur_act}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
